score_bcd_scheduler: RTL and testbench
======================================

SCORE_BCD_SCHEDULER -- requirements
Module: score_bcd_scheduler

Interface
REQ-001 Parameter H, default 32: playfield columns.
REQ-002 Parameter V, default 32: playfield rows; SB = logb2(H*V) is the score width (10 at defaults).
REQ-003 Parameter DIGITS, default 4: decimal digits per BCD result.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 score  in  SB  live binary score.
REQ-007 game_over  in  1  level; the rising edge marks end of game.
REQ-008 score_bcd  out  4*DIGITS  BCD of the last converted live score, most significant digit in the top nibble.
REQ-009 high_bcd  out  4*DIGITS  BCD of the stored high score.
REQ-010 busy  out  1  high while the shared converter is in SHIFT or COMMIT.
REQ-011 new_high  out  1  one-cycle pulse when the high score is replaced.

Function
REQ-012 One shared shift-add-3 (double-dabble) converter serves two requesters, LIVE and HIGH.
REQ-013 FSM states: IDLE, SHIFT, COMMIT.
- IDLE->SHIFT on grant.
- SHIFT->COMMIT after SB shifts.
- COMMIT->IDLE unconditionally.
REQ-014 LIVE request is pending while score != last_live, where last_live is the operand of the last granted LIVE conversion.
REQ-015 HIGH request:
- On the game_over rising edge (game_over high, game_over_q low) with score > high_raw: high_raw <= score, high_pend <= 1, new_high pulses in that same cycle.
- With score <= high_raw: nothing changes.
REQ-016 Arbitration in IDLE: HIGH has priority over LIVE; a LIVE request still pending is granted on the next IDLE.
REQ-017 Grant edge:
- Operand captured (LIVE: score, also written to last_live; HIGH: high_raw).
- BCD accumulator cleared; shift counter = 0.
REQ-018 Each SHIFT cycle: add 3 to every BCD digit >= 5, then shift {bcd, operand} left by 1; counter increments.
REQ-019 COMMIT writes the accumulator to score_bcd (LIVE) or high_bcd (HIGH); a HIGH commit clears high_pend.
REQ-020 Output timing:
- Grant edge to output-register update: exactly SB+1 edges.
- Outputs change only at COMMIT, all digits atomically.
REQ-021 Operand above 10^DIGITS-1 is saturated to 10^DIGITS-1 at capture.
REQ-022 Score changing during SHIFT/COMMIT does not affect the running conversion; the mismatch re-requests LIVE at the following IDLE.
REQ-023 A game_over rising edge during busy is still evaluated, sets high_pend, and is served at the next IDLE.
REQ-024 No request pending in IDLE: FSM stays idle, busy = 0.

Reset
REQ-025 rst_n low, asynchronously:
- FSM to IDLE.
- last_live, high_raw, score_bcd, high_bcd, accumulator and counter to 0.
- high_pend, game_over_q, busy, new_high to 0.
REQ-026 Reset mid-conversion aborts it with no partial result committed.

Structure
REQ-027 Shared package holds logb2, DIGITS default, BCD width (4*DIGITS), and the FSM state encodings.
REQ-028 One sub-module bcd_adjust: combinational per-digit add-3-if-≥5, instantiated DIGITS times.

Verification
REQ-029 Reset, then score=0 held 20 cycles -> busy stays 0; score_bcd=0x0000, high_bcd=0x0000.
REQ-030 score 0->1023 -> busy for 11 cycles; score_bcd=0x1023 exactly 11 edges after grant.
REQ-031 score=57, game_over 0->1 with high_raw=0 -> new_high pulses one cycle; HIGH granted before LIVE; high_bcd=0x0057, then score_bcd=0x0057.
REQ-032 score 5, then 6 during SHIFT -> score_bcd=0x0005 at first commit, 0x0006 after a second conversion.
REQ-033 high_raw=300, game_over rising edge with score=120 -> no new_high; high_bcd stays 0x0300.
REQ-034 rst_n low in 4th SHIFT cycle of score=999 -> all outputs 0 immediately; after release, score_bcd=0x0999 following a full 11-edge conversion.

Source files
------------

// File: rtl/score_bcd_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | score_bcd_scheduler_pkg: shared sizing helpers and FSM encoding      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package score_bcd_scheduler_pkg;

   localparam int c_digits_default = 4;
   localparam int c_bcd_w_default  = 4 * c_digits_default;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   // Bits needed to index n values (ceil log2).
   function automatic int logb2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int bcd_width(input int digits);
      return 4 * digits;
   endfunction

   function automatic int bcd_max(input int digits);
      int r;
      r = 1;
      for (int i = 0; i < digits; i++) r = r * 10;
      return r - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/score_bcd_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | score_bcd_scheduler_if: score inputs and BCD result outputs          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface score_bcd_scheduler_if #(
   parameter int SB    = 10,
   parameter int BCD_W = 16
);
   logic [SB-1:0]    score;
   logic             game_over;
   logic [BCD_W-1:0] score_bcd;
   logic [BCD_W-1:0] high_bcd;
   logic             busy;
   logic             new_high;

   modport master (
      output score, game_over,
      input  score_bcd, high_bcd, busy, new_high
   );

   modport slave (
      input  score, game_over,
      output score_bcd, high_bcd, busy, new_high
   );
endinterface
`default_nettype wire

// File: rtl/score_bcd_scheduler_bcd_adjust.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | score_bcd_scheduler_bcd_adjust (bcd_adjust): add 3 to a digit >= 5   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module score_bcd_scheduler_bcd_adjust (
   input  wire logic [3:0] din,
   output logic      [3:0] dout
);
   assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule
`default_nettype wire

// File: rtl/score_bcd_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | score_bcd_scheduler: one double-dabble converter shared by the live  |
// | score and the high score. Rev 1.0                                    |
// +----------------------------------------------------------------------+
module score_bcd_scheduler
   import score_bcd_scheduler_pkg::*;
#(
   parameter int H      = 32,
   parameter int V      = 32,
   parameter int DIGITS = c_digits_default
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   score_bcd_scheduler_if.slave  bus
);
   localparam int SB    = logb2(H * V);
   localparam int BCD_W = bcd_width(DIGITS);
   localparam int CW    = logb2(SB + 1);
   localparam int c_sat = bcd_max(DIGITS);

   state_e           state_q, state_d;
   logic [SB-1:0]    op_q, op_d;
   logic [BCD_W-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sel_high_q, sel_high_d;
   logic [SB-1:0]    last_live_q, last_live_d;
   logic [SB-1:0]    high_raw_q, high_raw_d;
   logic             high_pend_q, high_pend_d;
   logic             game_over_q;
   logic [BCD_W-1:0] score_bcd_q, score_bcd_d;
   logic [BCD_W-1:0] high_bcd_q, high_bcd_d;

   logic [BCD_W-1:0]    w_adj;
   logic [BCD_W+SB-1:0] w_shift;
   logic                w_new_high;

   function automatic logic [SB-1:0] saturate(input logic [SB-1:0] v);
      return (32'(v) > c_sat) ? SB'(c_sat) : v;
   endfunction

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      score_bcd_scheduler_bcd_adjust u_bcd_adjust (
         .din  (acc_q[4*i +: 4]),
         .dout (w_adj[4*i +: 4])
      );
   end

   assign w_shift    = {w_adj, op_q} << 1;
   assign w_new_high = bus.game_over && !game_over_q && (bus.score > high_raw_q);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sel_high_d  = sel_high_q;
      last_live_d = last_live_q;
      high_raw_d  = high_raw_q;
      high_pend_d = high_pend_q;
      score_bcd_d = score_bcd_q;
      high_bcd_d  = high_bcd_q;

      case (state_q)
         ST_IDLE: begin
            // A game-over hit seen this cycle already counts as a HIGH request.
            if (high_pend_q || w_new_high) begin
               state_d    = ST_SHIFT;
               sel_high_d = 1'b1;
               op_d       = saturate(w_new_high ? bus.score : high_raw_q);
               acc_d      = '0;
               cnt_d      = '0;
            end else if (bus.score != last_live_q) begin
               state_d     = ST_SHIFT;
               sel_high_d  = 1'b0;
               op_d        = saturate(bus.score);
               last_live_d = bus.score;
               acc_d       = '0;
               cnt_d       = '0;
            end
         end
         ST_SHIFT: begin
            acc_d = w_shift[BCD_W+SB-1:SB];
            op_d  = w_shift[SB-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(SB - 1)) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            if (sel_high_q) begin
               high_bcd_d  = acc_q;
               high_pend_d = 1'b0;
            end else begin
               score_bcd_d = acc_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A new high arriving during a HIGH commit must stay pending.
      if (w_new_high) begin
         high_raw_d  = bus.score;
         high_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sel_high_q  <= 1'b0;
         last_live_q <= '0;
         high_raw_q  <= '0;
         high_pend_q <= 1'b0;
         game_over_q <= 1'b0;
         score_bcd_q <= '0;
         high_bcd_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sel_high_q  <= sel_high_d;
         last_live_q <= last_live_d;
         high_raw_q  <= high_raw_d;
         high_pend_q <= high_pend_d;
         game_over_q <= bus.game_over;
         score_bcd_q <= score_bcd_d;
         high_bcd_q  <= high_bcd_d;
      end
   end

   assign bus.score_bcd = score_bcd_q;
   assign bus.high_bcd  = high_bcd_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.new_high  = rst_n && w_new_high;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_score_bcd_scheduler: directed and randomized checks of the BCD    |
// | scheduler against an arithmetic reference. Rev 1.0                   |
// +----------------------------------------------------------------------+
module tb_score_bcd_scheduler;
   localparam int SB    = 10;
   localparam int BCD_W = 16;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   model_high;

   score_bcd_scheduler_if #(.SB(SB), .BCD_W(BCD_W)) bus ();

   score_bcd_scheduler #(.H(32), .V(32), .DIGITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int value);
      logic [15:0] r;
      int v;
      v = (value > 9999) ? 9999 : value;
      r = '0;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The next rising edge must be the grant; checks hold, commit and busy length.
   task automatic conv_timing(input string tag, input bit is_high,
                              input logic [15:0] prev, input logic [15:0] exp);
      int bc;
      logic [15:0] o;
      bc = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (bus.busy) bc++;
         o = is_high ? bus.high_bcd : bus.score_bcd;
         if (k == 1)  check({tag, "_nh_low"}, 32'(bus.new_high), 32'd0);
         if (k == 11) check({tag, "_hold"}, 32'(o), 32'(prev));
         if (k == 12) check({tag, "_commit"}, 32'(o), 32'(exp));
      end
      check({tag, "_busy_cycles"}, 32'(bc), 32'd11);
   endtask

   initial begin
      int bc;
      int a;
      int b;
      int r;
      int g;
      bit exp_nh;
      total = 0;
      bad = 0;
      model_high = 0;
      bus.score = '0;
      bus.game_over = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) tick();
      check("rst_score_bcd", 32'(bus.score_bcd), 32'h0);
      check("rst_high_bcd", 32'(bus.high_bcd), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_new_high", 32'(bus.new_high), 32'd0);
      rst_n = 1'b1;

      // Idle with score already equal to last_live
      bc = 0;
      repeat (20) begin
         tick();
         if (bus.busy) bc++;
      end
      check("idle_busy_cycles", 32'(bc), 32'd0);
      check("idle_score_bcd", 32'(bus.score_bcd), 32'h0);
      check("idle_high_bcd", 32'(bus.high_bcd), 32'h0);

      // Full-range live conversion
      bus.score = 10'd1023;
      conv_timing("s1023", 1'b0, 16'h0000, to_bcd(1023));

      // High beats live on the same cycle
      bus.score = 10'd57;
      bus.game_over = 1'b1;
      #1;
      check("s57_new_high", 32'(bus.new_high), 32'd1);
      model_high = 57;
      conv_timing("s57_high", 1'b1, 16'h0000, to_bcd(57));
      conv_timing("s57_live", 1'b0, to_bcd(1023), to_bcd(57));

      // Score changes mid-conversion
      bus.game_over = 1'b0;
      tick();
      bus.score = 10'd5;
      tick();
      tick();
      tick();
      bus.score = 10'd6;
      repeat (8) tick();
      check("s5_hold", 32'(bus.score_bcd), 32'(to_bcd(57)));
      tick();
      check("s5_commit", 32'(bus.score_bcd), 32'(to_bcd(5)));
      conv_timing("s6", 1'b0, to_bcd(5), to_bcd(6));

      // Lower score at game over leaves the high score alone
      bus.score = 10'd300;
      bus.game_over = 1'b1;
      #1;
      check("s300_new_high", 32'(bus.new_high), 32'd1);
      model_high = 300;
      conv_timing("s300_high", 1'b1, to_bcd(57), to_bcd(300));
      conv_timing("s300_live", 1'b0, to_bcd(6), to_bcd(300));
      bus.game_over = 1'b0;
      tick();
      bus.score = 10'd120;
      bus.game_over = 1'b1;
      #1;
      check("s120_no_new_high", 32'(bus.new_high), 32'd0);
      repeat (14) tick();
      check("s120_high_kept", 32'(bus.high_bcd), 32'(to_bcd(300)));
      check("s120_score_bcd", 32'(bus.score_bcd), 32'(to_bcd(120)));

      // Reset in the 4th SHIFT cycle
      bus.game_over = 1'b0;
      tick();
      bus.score = 10'd999;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_score_bcd", 32'(bus.score_bcd), 32'h0);
      check("mid_rst_high_bcd", 32'(bus.high_bcd), 32'h0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_new_high", 32'(bus.new_high), 32'd0);
      model_high = 0;
      tick();
      tick();
      rst_n = 1'b1;
      conv_timing("s999_after_rst", 1'b0, 16'h0000, to_bcd(999));
      check("s999_high_bcd", 32'(bus.high_bcd), 32'h0);

      // Randomized score traffic with occasional game-over edges
      for (int it = 0; it < 20; it++) begin
         bus.game_over = 1'b0;
         tick();
         a = int'($urandom_range(0, 1023));
         bus.score = 10'(a);
         r = int'($urandom_range(0, 12));
         repeat (r) tick();
         b = int'($urandom_range(0, 1023));
         g = int'($urandom_range(0, 1));
         bus.score = 10'(b);
         bus.game_over = (g != 0);
         #1;
         exp_nh = (g != 0) && (b > model_high);
         check("rnd_new_high", 32'(bus.new_high), 32'(exp_nh));
         if (exp_nh) model_high = b;
         repeat (40) tick();
         check("rnd_busy_idle", 32'(bus.busy), 32'd0);
         check("rnd_score_bcd", 32'(bus.score_bcd), 32'(to_bcd(b)));
         check("rnd_high_bcd", 32'(bus.high_bcd), 32'(to_bcd(model_high)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
